gp_regfile: RTL
===============

Name: gp_regfile

Overview:
- Parametrised successor to the fixed 4x16 general-purpose register bank in VR16.
- Provides NUM_REGS registers of DATA_W bits, one write port and two asynchronous read ports (ALU operands A and B).
- Adds a per-register busy scoreboard so the control unit can stall on in-flight results.
- Adds a one-cycle write_done acknowledge pulse.

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 4, number of registers; valid range 2..64.
- ADDR_W, $clog2(NUM_REGS), derived localparam, not overridable; width of all address ports.

Ports:
- clk  input  1  system clock, all state updates on its rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- write_enable  input  1  commit write_data to register write_addr this cycle
- write_addr  input  ADDR_W  destination register index
- write_data  input  DATA_W  value to store (ALU result)
- write_done  output  1  one-cycle pulse, cycle after an accepted write
- reserve_en  input  1  mark register reserve_addr busy (instruction issued)
- reserve_addr  input  ADDR_W  register to reserve
- rd_addr_a  input  ADDR_W  read port A index
- rd_data_a  output  DATA_W  read port A data
- rd_busy_a  output  1  register rd_addr_a has a pending write
- rd_addr_b  input  ADDR_W  read port B index
- rd_data_b  output  DATA_W  read port B data
- rd_busy_b  output  1  register rd_addr_b has a pending write
- busy_vec  output  NUM_REGS  scoreboard, bit i = register i busy
- regs_flat  output  NUM_REGS*DATA_W  debug view, register i at bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset: all registers, busy_vec and write_done cleared to 0 on the first rising edge with reset=1. write_enable and reserve_en are ignored in that cycle. Reset aborts any pending reservation.
- Write: on the rising edge with write_enable=1 and write_addr<NUM_REGS, register[write_addr] takes write_data, busy[write_addr] clears, and write_done=1 in the following cycle only.
- Back-to-back writes keep write_done high for consecutive cycles, one per write.
- Out-of-range write (write_addr>=NUM_REGS, possible only for non-power-of-2 NUM_REGS): no state change and no write_done.
- Reserve: on the rising edge with reserve_en=1 and a valid reserve_addr, busy[reserve_addr] sets. An out-of-range reserve is ignored.
- Reserve and write in the same cycle:
  - Same address: data is written and busy stays set (reserve wins; a new producer is in flight).
  - Different addresses: both take effect.
- Reserving an already-busy register: no change.
- Reads: combinational, zero latency. rd_data_x = register[rd_addr_x] and rd_busy_x = busy[rd_addr_x].
- Out-of-range read returns data 0 and busy 0.
- Both read ports may address the same register.
- Without bypass, a read in the same cycle as a write to that address returns the old value and the old busy state.
- write_done is registered; regs_flat and busy_vec reflect register state directly, so updates are visible right after the edge.

Optional Feature:
- Macro: GP_REGFILE_BYPASS_EN.
- Defined: when write_enable=1 and a valid write_addr equals rd_addr_x, rd_data_x = write_data and rd_busy_x = 0 in the same cycle. The exception is a simultaneous same-address reserve, where rd_busy_x = 1. busy_vec and regs_flat are not bypassed.
- Undefined: reads show only registered state, as described in Behaviour.

Decomposition:
- Shared package vr16_pkg holds:
  - VR16_DATA_W=16 and VR16_NUM_REGS=4 defaults
  - register index constants REG_A=0, REG_B=1, REG_C=2, REG_D=3
  - an addr_t typedef sized from VR16_NUM_REGS
- Natural sub-module gp_scoreboard, which owns the busy_vec set/clear logic, reserve-wins priority and out-of-range masking.
- Storage and read muxing stay in gp_regfile.

Test Plan:
- Reset with all registers holding 0xFFFF: drive reset=1 for one edge → all regs_flat 0, busy_vec 0, write_done 0. A write_enable asserted in the same cycle is ignored.
- Write 0x1234 to reg 2 at edge N → rd_data_a(addr 2)=0x1234 after edge N, and write_done=1 only during cycle N+1. Write 0xBEEF to reg 3 at N+1 → write_done also high in cycle N+2.
- Reserve reg 1 → busy_vec=4'b0010 and rd_busy_b(addr 1)=1. Later, write 0x00AA to reg 1 → busy_vec=0 and rd_data_b=0x00AA.
- Reserve and write reg 0 in the same cycle with data 0x5555 → reg 0=0x5555 and busy_vec[0]=1.
- Read reg 3 (holding 0x0001) on both ports while writing 0x0F0F to reg 3:
  - bypass off: both ports show 0x0001 that cycle, then 0x0F0F.
  - GP_REGFILE_BYPASS_EN: both ports show 0x0F0F immediately with busy 0.
- NUM_REGS=6, DATA_W=32: write to addr 7 → no state change and no write_done. Read addr 6 → data 0, busy 0. Write 0xDEADBEEF to addr 5 → regs_flat[191:160]=0xDEADBEEF.

Source files
------------

// File: rtl/vr16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vr16_pkg
// Purpose  : Shared definitions for the VR16 register bank family. Holds the
//            default geometry, the architectural register index constants and
//            the address type sized from the default register count.
// Ports    : none (package)
// Revision : 1.0 - initial parametrised release
// ============================================================================
package vr16_pkg;

  localparam int VR16_DATA_W   = 16;
  localparam int VR16_NUM_REGS = 4;
  localparam int VR16_ADDR_W   = $clog2(VR16_NUM_REGS);

  typedef logic [VR16_ADDR_W-1:0] addr_t;

  // Architectural names of the four legacy VR16 registers
  localparam addr_t REG_A = addr_t'(0);
  localparam addr_t REG_B = addr_t'(1);
  localparam addr_t REG_C = addr_t'(2);
  localparam addr_t REG_D = addr_t'(3);

endpackage
`default_nettype wire

// File: rtl/gp_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : gp_regfile_if
// Purpose  : Bundles the write port, reserve port, two read ports and the
//            debug/scoreboard views of gp_regfile.
// Ports    : master - control unit / datapath side (drives addresses, data)
//            slave  - register file side (drives read data, busy, write_done)
// Revision : 1.0 - initial parametrised release
// ============================================================================
interface gp_regfile_if
  import vr16_pkg::*;
#(
  parameter int DATA_W   = VR16_DATA_W,
  parameter int NUM_REGS = VR16_NUM_REGS
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic                         write_enable;
  logic [ADDR_W-1:0]            write_addr;
  logic [DATA_W-1:0]            write_data;
  logic                         write_done;
  logic                         reserve_en;
  logic [ADDR_W-1:0]            reserve_addr;
  logic [ADDR_W-1:0]            rd_addr_a;
  logic [DATA_W-1:0]            rd_data_a;
  logic                         rd_busy_a;
  logic [ADDR_W-1:0]            rd_addr_b;
  logic [DATA_W-1:0]            rd_data_b;
  logic                         rd_busy_b;
  logic [NUM_REGS-1:0]          busy_vec;
  logic [NUM_REGS*DATA_W-1:0]   regs_flat;

  modport master (
    output write_enable, write_addr, write_data,
    output reserve_en, reserve_addr,
    output rd_addr_a, rd_addr_b,
    input  write_done, rd_data_a, rd_busy_a, rd_data_b, rd_busy_b,
    input  busy_vec, regs_flat
  );

  modport slave (
    input  write_enable, write_addr, write_data,
    input  reserve_en, reserve_addr,
    input  rd_addr_a, rd_addr_b,
    output write_done, rd_data_a, rd_busy_a, rd_data_b, rd_busy_b,
    output busy_vec, regs_flat
  );

endinterface
`default_nettype wire

// File: rtl/gp_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : gp_scoreboard
// Purpose  : Per-register busy tracking. A reserve marks a register busy, a
//            write clears it; when both hit the same register the reserve
//            wins because a newer producer is already in flight. Addresses
//            at or beyond NUM_REGS are masked out.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            write_enable/write_addr - write port strobe and index
//            reserve_en/reserve_addr - reserve strobe and index
//            busy_vec                - busy bit per register
//            write_ok                - write strobe qualified by range check
// Revision : 1.0 - initial release
// ============================================================================
module gp_scoreboard #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_enable,
  input  logic [ADDR_W-1:0]   write_addr,
  input  logic                reserve_en,
  input  logic [ADDR_W-1:0]   reserve_addr,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                write_ok
);

  // One extra bit so that NUM_REGS itself is representable (e.g. 64 with 6-bit addresses)
  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

  logic reserve_ok;

  assign write_ok   = write_enable && ({1'b0, write_addr}   < REG_LIMIT);
  assign reserve_ok = reserve_en   && ({1'b0, reserve_addr} < REG_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_vec <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // Set is checked first so a same-register reserve overrides the clear
        if (reserve_ok && (reserve_addr == ADDR_W'(i))) begin
          busy_vec[i] <= 1'b1;
        end else if (write_ok && (write_addr == ADDR_W'(i))) begin
          busy_vec[i] <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gp_regfile.sv
`default_nettype none
// ============================================================================
// Module   : gp_regfile
// Purpose  : NUM_REGS x DATA_W general-purpose register file with one write
//            port, two combinational read ports, a busy scoreboard and a
//            one-cycle write_done acknowledge.
// Ports    : clk   - system clock, rising-edge active
//            reset - synchronous active-high reset
//            bus   - gp_regfile_if.slave: write/reserve/read ports, busy_vec,
//                    write_done and the regs_flat debug view
// Options  : GP_REGFILE_BYPASS_EN - forward the in-flight write data (and a
//            cleared busy, unless re-reserved in the same cycle) to read
//            ports addressing the register being written.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module gp_regfile
  import vr16_pkg::*;
#(
  parameter int DATA_W   = VR16_DATA_W,
  parameter int NUM_REGS = VR16_NUM_REGS
) (
  input  logic        clk,
  input  logic        reset,
  gp_regfile_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0]          regs [NUM_REGS];
  logic [NUM_REGS-1:0]        busy;
  logic                       write_ok;
  logic                       done_pulse;
  logic [NUM_REGS*DATA_W-1:0] flat;
  logic [DATA_W-1:0]          data_a;
  logic [DATA_W-1:0]          data_b;
  logic                       busy_a;
  logic                       busy_b;

  gp_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .write_enable (bus.write_enable),
    .write_addr   (bus.write_addr),
    .reserve_en   (bus.reserve_en),
    .reserve_addr (bus.reserve_addr),
    .busy_vec     (busy),
    .write_ok     (write_ok)
  );

  // Storage and the write acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= write_ok;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (write_ok && (bus.write_addr == ADDR_W'(i))) begin
          regs[i] <= bus.write_data;
        end
      end
    end
  end

  always_comb begin
    flat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      flat[i*DATA_W +: DATA_W] = regs[i];
    end
  end

  // Read port A: the compare loop leaves out-of-range addresses at 0 / not busy
  always_comb begin
    data_a = '0;
    busy_a = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_addr_a == ADDR_W'(i)) begin
        data_a = regs[i];
        busy_a = busy[i];
      end
    end
`ifdef GP_REGFILE_BYPASS_EN
    if (write_ok && (bus.write_addr == bus.rd_addr_a)) begin
      data_a = bus.write_data;
      // write_ok already implies the address is in range
      busy_a = bus.reserve_en && (bus.reserve_addr == bus.write_addr);
    end
`endif
  end

  // Read port B: same structure as port A
  always_comb begin
    data_b = '0;
    busy_b = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_addr_b == ADDR_W'(i)) begin
        data_b = regs[i];
        busy_b = busy[i];
      end
    end
`ifdef GP_REGFILE_BYPASS_EN
    if (write_ok && (bus.write_addr == bus.rd_addr_b)) begin
      data_b = bus.write_data;
      busy_b = bus.reserve_en && (bus.reserve_addr == bus.write_addr);
    end
`endif
  end

  assign bus.rd_data_a  = data_a;
  assign bus.rd_busy_a  = busy_a;
  assign bus.rd_data_b  = data_b;
  assign bus.rd_busy_b  = busy_b;
  assign bus.busy_vec   = busy;
  assign bus.regs_flat  = flat;
  assign bus.write_done = done_pulse;

endmodule
`default_nettype wire
